// File: rtl/cla_wide_seq_ctrl.sv
// Wide add/subtract sequencer: one 4-bit carry-lookahead slice reused once per nibble,
// least-significant nibble first, with valid/ready handshakes on operands and result.
module cla_wide_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*WORDS-1:0]   a,
    input  logic [4*WORDS-1:0]   b,
    input  logic                 sel,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*WORDS-1:0]   sum,
    output logic                 c_out,
    output logic                 overflow,
    output logic                 busy
);

    localparam int W  = 4 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sel_q;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] bb;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] nib_sum;

    always_comb begin
        nib_a = a_q[4*idx +: 4];
        nib_b = b_q[4*idx +: 4];
        bb    = sel_q ? ~nib_b : nib_b;
        p     = nib_a ^ bb;
        g     = nib_a & bb;
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_sum = p ^ c[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sel_q <= sel;
                        idx   <= '0;
                        carry <= sel;
                        state <= StRun;
                    end
                end
                StRun: begin
                    sum[4*idx +: 4] <= nib_sum;
                    carry           <= c[4];
                    idx             <= idx + 1'b1;
                    if (idx == LAST) begin
                        c_out    <= c[4];
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        overflow <= c[3] ^ c[4];
                        state    <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign start_ready = (state == StIdle) && !rst;
    assign res_valid   = (state == StDone);
    assign busy        = (state != StIdle);

endmodule

// File: tb/tb_cla_wide_seq_ctrl.sv
// Directed bench for cla_wide_seq_ctrl (WORDS=4): vector table plus hold, reset and
// back-to-back handshake sequences.
module tb_cla_wide_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    cla_wide_seq_ctrl #(.WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sel         (sel),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .c_out       (c_out),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sel;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at the negedge just after the accept edge; counts edges until res_valid.
    task automatic wait_result(input string name, input logic [15:0] es, input logic eco,
                               input logic eov);
        int lat;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 4);
        check({name, " sum"}, {16'h0, sum}, {16'h0, es});
        check({name, " c_out"}, {31'h0, c_out}, {31'h0, eco});
        check({name, " overflow"}, {31'h0, overflow}, {31'h0, eov});
    endtask

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready before accept", {31'h0, start_ready}, 32'h1);
        start_valid = 1'b1;
        a = ta;
        b = tb_;
        sel = ts;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        sel = ~ts;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("idle after handshake", {30'h0, start_ready, busy}, 32'h2);
    endtask

    initial begin
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1235, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h5A5A, 16'hA5A5, 1'b1, 16'hB4B5, 1'b0, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[10] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};

        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0;
        b = '0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {sum, 12'h0, c_out, overflow, res_valid, busy}, 32'h0);
        rst = 1'b0;
        #1;
        check("reset ready", {31'h0, start_ready}, 32'h1);

        for (int i = 0; i < 11; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].sel);
            wait_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
            release_result();
        end

        // Hold in DONE while a new request is offered; it must not be taken.
        accept(16'h1111, 16'h2222, 1'b0);
        wait_result("hold", 16'h3333, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            start_valid = (k % 2 == 0);
            a = 16'hFFFF;
            b = 16'hFFFF;
            @(negedge clk);
            check($sformatf("hold cyc%0d", k), {13'h0, res_valid, start_ready, busy, sum},
                  {13'h0, 1'b1, 1'b0, 1'b1, 16'h3333});
        end
        start_valid = 1'b0;
        release_result();
        @(negedge clk);
        check("hold not captured", {15'h0, busy, sum}, {15'h0, 1'b0, 16'h3333});

        // Reset after the second nibble write; previous result is 0x3333.
        accept(16'hABCD, 16'h1111, 1'b0);
        @(negedge clk);
        check("partial nib1", {16'h0, sum}, 32'h333E);
        @(negedge clk);
        check("partial nib2", {16'h0, sum}, 32'h33DE);
        rst = 1'b1;
        #1;
        check("abort outputs", {sum, 11'h0, c_out, overflow, res_valid, busy, start_ready},
              32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready", {30'h0, start_ready, busy}, 32'h2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort no result %0d", k), {30'h0, res_valid, busy}, 32'h0);
        end

        // Back-to-back: second request waits on start_valid through the handshake.
        accept(16'h1000, 16'h0234, 1'b0);
        wait_result("b2b first", 16'h1234, 1'b0, 1'b0);
        start_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h0101;
        sel = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("b2b idle gap", {30'h0, start_ready, res_valid}, 32'h2);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        check("b2b accepted", {31'h0, busy}, 32'h1);
        wait_result("b2b second", 16'h0E0E, 1'b1, 1'b0);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
